sha256_pad_writer: RTL and testbench
====================================

SHA256_PAD_WRITER -- requirements
Module: sha256_pad_writer

Interface
REQ-001 Parameter: none; buffer geometry is fixed at 128 bytes, i.e. two 512-bit blocks at byte addresses 0..127.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 start  in  1  begin new message; honoured only in IDLE.
REQ-005 in_valid  in  1  in_data holds a message byte.
REQ-006 in_data  in  8  message byte, in message order.
REQ-007 in_last  in  1  qualifies the current byte as the final message byte.
REQ-008 in_ready  out  1  byte accepted on edge where in_valid=1 and in_ready=1.
REQ-009 wr_en  out  1  wr_addr/wr_data carry a new write this cycle.
REQ-010 wr_addr  out  8  byte address of the write, 0..127.
REQ-011 wr_data  out  8  byte value to write.
REQ-012 done  out  1  one-cycle pulse: padded image complete.
REQ-013 nblocks  out  2  number of 512-bit blocks in the image (1 or 2); valid from done until the next start.
REQ-014 err  out  1  overflow flag: message exceeded 119 bytes; held until next start or reset.

Function
REQ-015 Message length L SHALL be 1..119 bytes; end address E = 64 if L<=55, else E = 128.
REQ-016 States SHALL be IDLE, LOAD, PAD80, ZERO, LEN, DONE, ERR; one write per cycle at most.
REQ-017 IDLE: in_ready=0, wr_en=0; start=1 clears byte count to 0, clears err, goes to LOAD; start in any other state is ignored.
REQ-018 LOAD: in_ready=1 while count<119 or in_last path open; each accepted byte is written at wr_addr=count, count increments.
REQ-019 An accepted byte with in_last=1 SHALL set L=count+1 and move to PAD80; in_valid gaps insert no writes and do not advance count.
REQ-020 A 120th byte accepted without in_last having been seen SHALL not be written; instead err=1, in_ready=0, go to ERR; ERR holds until start (acts as IDLE start) or reset; no done pulse.
REQ-021 PAD80: one write of 0x80 at address L, then ZERO if L+1 < E-8, else LEN.
REQ-022 ZERO: write 0x00 at addresses L+1 .. E-9 ascending, one per cycle, then LEN.
REQ-023 LEN: write 64-bit big-endian bit length L*8 at E-8..E-1: bytes E-8..E-3 = 0x00, E-2 = {6'b0, L*8[9:8]}, E-1 = L*8[7:0].
REQ-024 DONE: done=1 for exactly one cycle, nblocks = E/64 latched, then IDLE.
REQ-025 wr_* outputs SHALL be registered: byte accepted on edge k appears on wr_* (wr_en=1) in the cycle after edge k.
REQ-026 Latency: last message byte accepted on edge t -> 0x80 presented after edge t+1, final length byte after edge t+(E-L), done asserted after edge t+(E-L)+1.
REQ-027 When wr_en=0, wr_addr and wr_data SHALL hold the last written address and byte, so an enable-less consumer rewrites an unchanged value.
REQ-028 Addresses SHALL never exceed E-1 for the current message; bytes at E..127 when E=64 are not written.

Reset
REQ-029 rst_n=0 at an edge, in any state including mid-LOAD/ZERO/LEN, SHALL force IDLE, count=0, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, done=0, nblocks=0, err=0.
REQ-030 A message interrupted by reset is discarded; no done pulse is produced for it.

Verification
REQ-031 "abc" (0x61,0x62,0x63, last on 0x63) -> writes 0..2 = data, 3 = 0x80, 4..61 = 0x00, 62 = 0x00, 63 = 0x18; nblocks=1; done 62 cycles after last-byte edge.
REQ-032 L=55 -> 55 = 0x80, 56..61 = 0x00, no ZERO state, 62 = 0x01, 63 = 0xB8; nblocks=1.
REQ-033 L=56 -> 56 = 0x80, 57..125 = 0x00, 126 = 0x01, 127 = 0xC0; nblocks=2.
REQ-034 L=119 -> 119 = 0x80, 120..125 = 0x00, 126 = 0x03, 127 = 0xB8; nblocks=2; in_valid toggled 1/0 each cycle gives identical image.
REQ-035 120 bytes without in_last -> err=1 after 120th accept, in_ready=0, no write at 119 beyond byte 118 data... i.e. last write address 118, no done; start clears err.
REQ-036 rst_n=0 during ZERO of L=10 message -> all outputs 0 next cycle; following start + "abc" yields REQ-031 image exactly.

Source files
------------

// File: rtl/sha256_pad_writer_if.sv
// Byte-stream in / byte-write out bus for the SHA-256 pad writer.
//   start, in_valid, in_data, in_last : message stream from the producer
//   in_ready                          : byte accepted when in_valid && in_ready
//   wr_en, wr_addr, wr_data           : byte writes into the 128-byte block buffer
//   done, nblocks, err                : completion pulse, block count, overflow flag
// slave is the pad writer side, master is the producer/consumer side.
interface sha256_pad_writer_if;
   logic       start;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_last;
   logic       in_ready;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       done;
   logic [1:0] nblocks;
   logic       err;

   modport slave (
      input  start, in_valid, in_data, in_last,
      output in_ready, wr_en, wr_addr, wr_data, done, nblocks, err
   );

   modport master (
      output start, in_valid, in_data, in_last,
      input  in_ready, wr_en, wr_addr, wr_data, done, nblocks, err
   );
endinterface

// File: rtl/sha256_pad_writer.sv
// SHA-256 message padder. Streams a 1..119 byte message into a 128-byte
// buffer (one or two 512-bit blocks) and appends 0x80, zero fill and the
// 64-bit big-endian bit length, one byte write per cycle.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : sha256_pad_writer_if.slave (stream in, byte writes out, status)
module sha256_pad_writer (
   input  logic clk,
   input  logic rst_n,
   sha256_pad_writer_if.slave bus
);

   typedef enum logic [2:0] {IDLE, LOAD, PAD80, ZERO, LEN, DONE, ERR} state_t;

   state_t     state;
   logic [6:0] count;
   logic [6:0] len;
   logic       two_blk;
   logic [7:0] end_addr;
   logic [7:0] nxt_addr;
   logic [9:0] bit_len;

   // Messages longer than 55 bytes cannot fit 0x80 plus the length in one block.
   assign two_blk  = (len > 7'd55);
   assign end_addr = two_blk ? 8'd128 : 8'd64;
   assign nxt_addr = bus.wr_addr + 8'd1;
   assign bit_len  = {len, 3'b000};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         count        <= '0;
         len          <= '0;
         bus.in_ready <= 1'b0;
         bus.wr_en    <= 1'b0;
         bus.wr_addr  <= '0;
         bus.wr_data  <= '0;
         bus.done     <= 1'b0;
         bus.nblocks  <= '0;
         bus.err      <= 1'b0;
      end else begin
         // wr_addr/wr_data are only loaded on a write, so they hold otherwise.
         bus.wr_en <= 1'b0;
         bus.done  <= 1'b0;
         case (state)
            IDLE, ERR: begin
               if (bus.start) begin
                  count        <= '0;
                  bus.err      <= 1'b0;
                  bus.nblocks  <= '0;
                  bus.in_ready <= 1'b1;
                  state        <= LOAD;
               end
            end
            LOAD: begin
               if (bus.in_valid && bus.in_ready) begin
                  if (count == 7'd119) begin
                     // 120th byte: overflow, byte is dropped.
                     bus.err      <= 1'b1;
                     bus.in_ready <= 1'b0;
                     state        <= ERR;
                  end else begin
                     bus.wr_en   <= 1'b1;
                     bus.wr_addr <= {1'b0, count};
                     bus.wr_data <= bus.in_data;
                     count       <= count + 7'd1;
                     if (bus.in_last) begin
                        len          <= count + 7'd1;
                        bus.in_ready <= 1'b0;
                        state        <= PAD80;
                     end
                  end
               end
            end
            PAD80: begin
               bus.wr_en   <= 1'b1;
               bus.wr_addr <= {1'b0, len};
               bus.wr_data <= 8'h80;
               // Skip ZERO when the length field starts right after 0x80.
               if (({1'b0, len} + 8'd1) < (end_addr - 8'd8)) state <= ZERO;
               else                                           state <= LEN;
            end
            ZERO: begin
               bus.wr_en   <= 1'b1;
               bus.wr_addr <= nxt_addr;
               bus.wr_data <= 8'h00;
               if (nxt_addr == (end_addr - 8'd9)) state <= LEN;
            end
            LEN: begin
               bus.wr_en   <= 1'b1;
               bus.wr_addr <= nxt_addr;
               // Bit length is at most 952, so only the last two bytes are non-zero.
               if (nxt_addr == (end_addr - 8'd2))
                  bus.wr_data <= {6'b0, bit_len[9:8]};
               else if (nxt_addr == (end_addr - 8'd1))
                  bus.wr_data <= bit_len[7:0];
               else
                  bus.wr_data <= 8'h00;
               if (nxt_addr == (end_addr - 8'd1)) state <= DONE;
            end
            DONE: begin
               bus.done    <= 1'b1;
               bus.nblocks <= two_blk ? 2'd2 : 2'd1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_pad_writer.sv
// Directed bench for sha256_pad_writer: reset, one/two block images,
// boundary lengths, in_valid gaps, overflow and mid-pad reset.
module tb_sha256_pad_writer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sha256_pad_writer_if bus ();

   sha256_pad_writer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   logic rst_q = 1'b0;

   logic [7:0] mem [0:127];
   logic [7:0] saved [0:127];
   int nwr, ndone, done_cyc, last_addr, max_addr, hold_bad;
   logic [7:0] prev_a, prev_d;

   function automatic logic [7:0] mb(int i);
      return 8'h61 + 8'(i);
   endfunction

   // Reference image: message, 0x80, zeros, big-endian bit length; 0x5A = never written.
   function automatic logic [7:0] exp_byte(int L, int a);
      int e;
      e = (L <= 55) ? 64 : 128;
      if (a >= e)         return 8'h5A;
      if (a < L)          return mb(a);
      if (a == L)         return 8'h80;
      if (a == e - 2)     return 8'((L * 8) / 256);
      if (a == e - 1)     return 8'((L * 8) % 256);
      return 8'h00;
   endfunction

   function automatic int image_bad(int L);
      for (int a = 0; a < 128; a++)
         if (mem[a] !== exp_byte(L, a)) return a;
      return -1;
   endfunction

   // One clock: let the edge happen, then sample outputs on the falling edge.
   task automatic tick();
      @(posedge clk);
      cyc++;
      rst_q = rst_n;
      @(negedge clk);
      if (bus.wr_en === 1'b1) begin
         mem[bus.wr_addr[6:0]] = bus.wr_data;
         nwr++;
         last_addr = int'(bus.wr_addr);
         if (int'(bus.wr_addr) > max_addr) max_addr = int'(bus.wr_addr);
         prev_a = bus.wr_addr;
         prev_d = bus.wr_data;
      end else begin
         if (!rst_q) begin prev_a = 8'h00; prev_d = 8'h00; end
         if (bus.wr_addr !== prev_a || bus.wr_data !== prev_d) hold_bad++;
      end
      if (bus.done === 1'b1) begin
         ndone++;
         done_cyc = cyc;
      end
   endtask

   task automatic clear_log();
      for (int a = 0; a < 128; a++) mem[a] = 8'h5A;
      nwr = 0; ndone = 0; done_cyc = 0; last_addr = -1; max_addr = 0; hold_bad = 0;
   endtask

   task automatic send_msg(input int L, input bit gaps, output int t_last);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      t_last = 0;
      for (int i = 0; i < L; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = mb(i);
         bus.in_last  = (i == L - 1);
         tick();
         if (i == L - 1) t_last = cyc;
         if (gaps) begin
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
            tick();
         end
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int n = 0; n < budget && ndone == 0; n++) tick();
   endtask

   task automatic test_reset();
      logic [22:0] outs;
      rst_n = 1'b0;
      bus.start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'hFF; bus.in_last = 1'b0;
      tick(); tick();
      outs = {bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.done, bus.nblocks, bus.err};
      tests++;
      if (outs !== 23'd0) begin
         fails++; $display("FAIL reset_outputs: got %h want 0", outs);
      end
      rst_n = 1'b1; bus.start = 1'b0; bus.in_valid = 1'b0;
      tick();
      tests++;
      if (bus.in_ready !== 1'b0 || bus.wr_en !== 1'b0) begin
         fails++; $display("FAIL reset_idle: in_ready=%b wr_en=%b want 0 0", bus.in_ready, bus.wr_en);
      end
   endtask

   task automatic test_abc();
      int t, bad;
      clear_log();
      send_msg(3, 1'b0, t);
      wait_done(200);
      bad = image_bad(3);
      tests++;
      if (bad >= 0) begin
         fails++; $display("FAIL abc_image: addr %0d got %h want %h", bad, mem[bad], exp_byte(3, bad));
      end
      tests++;
      if (mem[3] !== 8'h80 || mem[62] !== 8'h00 || mem[63] !== 8'h18) begin
         fails++; $display("FAIL abc_tail: got %h %h %h want 80 00 18", mem[3], mem[62], mem[63]);
      end
      tests++;
      if (done_cyc - t != 62) begin
         fails++; $display("FAIL abc_latency: got %0d want 62", done_cyc - t);
      end
      tests++;
      if (bus.nblocks !== 2'd1 || nwr != 64) begin
         fails++; $display("FAIL abc_count: nblocks=%0d writes=%0d want 1 64", bus.nblocks, nwr);
      end
      tick();
      tests++;
      if (bus.done !== 1'b0 || ndone != 1) begin
         fails++; $display("FAIL abc_done_pulse: done=%b pulses=%0d want 0 1", bus.done, ndone);
      end
      tests++;
      if (hold_bad != 0) begin
         fails++; $display("FAIL abc_hold: got %0d hold violations want 0", hold_bad);
      end
   endtask

   task automatic test_len55();
      int t, bad;
      clear_log();
      send_msg(55, 1'b0, t);
      wait_done(200);
      bad = image_bad(55);
      tests++;
      if (bad >= 0) begin
         fails++; $display("FAIL len55_image: addr %0d got %h want %h", bad, mem[bad], exp_byte(55, bad));
      end
      tests++;
      if (mem[55] !== 8'h80 || mem[62] !== 8'h01 || mem[63] !== 8'hB8 || max_addr != 63) begin
         fails++; $display("FAIL len55_tail: got %h %h %h max %0d want 80 01 b8 63",
                           mem[55], mem[62], mem[63], max_addr);
      end
      tests++;
      if (done_cyc - t != 10 || bus.nblocks !== 2'd1) begin
         fails++; $display("FAIL len55_done: latency %0d nblocks %0d want 10 1", done_cyc - t, bus.nblocks);
      end
   endtask

   task automatic test_len56();
      int t, bad;
      clear_log();
      send_msg(56, 1'b0, t);
      // A start pulse during padding must be ignored.
      tick(); tick();
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      wait_done(200);
      bad = image_bad(56);
      tests++;
      if (bad >= 0) begin
         fails++; $display("FAIL len56_image: addr %0d got %h want %h", bad, mem[bad], exp_byte(56, bad));
      end
      tests++;
      if (mem[56] !== 8'h80 || mem[126] !== 8'h01 || mem[127] !== 8'hC0) begin
         fails++; $display("FAIL len56_tail: got %h %h %h want 80 01 c0", mem[56], mem[126], mem[127]);
      end
      tests++;
      if (done_cyc - t != 73 || bus.nblocks !== 2'd2 || ndone != 1) begin
         fails++; $display("FAIL len56_done: latency %0d nblocks %0d pulses %0d want 73 2 1",
                           done_cyc - t, bus.nblocks, ndone);
      end
   endtask

   task automatic test_len119_gaps();
      int t, bad, diff;
      clear_log();
      send_msg(119, 1'b0, t);
      wait_done(200);
      for (int a = 0; a < 128; a++) saved[a] = mem[a];
      bad = image_bad(119);
      tests++;
      if (bad >= 0) begin
         fails++; $display("FAIL len119_image: addr %0d got %h want %h", bad, mem[bad], exp_byte(119, bad));
      end
      tests++;
      if (mem[119] !== 8'h80 || mem[126] !== 8'h03 || mem[127] !== 8'hB8 || bus.nblocks !== 2'd2) begin
         fails++; $display("FAIL len119_tail: got %h %h %h nblocks %0d want 80 03 b8 2",
                           mem[119], mem[126], mem[127], bus.nblocks);
      end
      clear_log();
      send_msg(119, 1'b1, t);
      wait_done(200);
      diff = -1;
      for (int a = 127; a >= 0; a--) if (mem[a] !== saved[a]) diff = a;
      tests++;
      if (diff >= 0) begin
         fails++; $display("FAIL gaps_image: addr %0d got %h want %h", diff, mem[diff], saved[diff]);
      end
      tests++;
      if (done_cyc - t != 10 || nwr != 128 || hold_bad != 0) begin
         fails++; $display("FAIL gaps_done: latency %0d writes %0d holdbad %0d want 10 128 0",
                           done_cyc - t, nwr, hold_bad);
      end
   endtask

   task automatic test_overflow();
      clear_log();
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      for (int i = 0; i < 120; i++) begin
         bus.in_valid = 1'b1; bus.in_data = mb(i); bus.in_last = 1'b0;
         tick();
      end
      bus.in_valid = 1'b0;
      tests++;
      if (bus.err !== 1'b1 || bus.in_ready !== 1'b0) begin
         fails++; $display("FAIL ovf_flag: err=%b in_ready=%b want 1 0", bus.err, bus.in_ready);
      end
      tests++;
      if (last_addr != 118 || nwr != 119) begin
         fails++; $display("FAIL ovf_writes: last %0d count %0d want 118 119", last_addr, nwr);
      end
      for (int n = 0; n < 80; n++) tick();
      tests++;
      if (ndone != 0 || bus.err !== 1'b1 || nwr != 119) begin
         fails++; $display("FAIL ovf_hold: pulses %0d err %b writes %0d want 0 1 119", ndone, bus.err, nwr);
      end
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      tests++;
      if (bus.err !== 1'b0 || bus.in_ready !== 1'b1) begin
         fails++; $display("FAIL ovf_restart: err=%b in_ready=%b want 0 1", bus.err, bus.in_ready);
      end
      // Close the restarted message so the block returns to IDLE.
      bus.in_valid = 1'b1; bus.in_data = 8'h00; bus.in_last = 1'b1;
      tick();
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
      wait_done(200);
      tick();
   endtask

   task automatic test_reset_mid();
      int t, bad;
      logic [22:0] outs;
      clear_log();
      send_msg(10, 1'b0, t);
      for (int n = 0; n < 6; n++) tick();
      rst_n = 1'b0;
      tick();
      outs = {bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.done, bus.nblocks, bus.err};
      tests++;
      if (outs !== 23'd0) begin
         fails++; $display("FAIL midreset_outputs: got %h want 0", outs);
      end
      rst_n = 1'b1;
      for (int n = 0; n < 80; n++) tick();
      tests++;
      if (ndone != 0) begin
         fails++; $display("FAIL midreset_nodone: got %0d pulses want 0", ndone);
      end
      clear_log();
      send_msg(3, 1'b0, t);
      wait_done(200);
      bad = image_bad(3);
      tests++;
      if (bad >= 0 || done_cyc - t != 62 || bus.nblocks !== 2'd1) begin
         fails++; $display("FAIL midreset_abc: bad addr %0d latency %0d nblocks %0d want -1 62 1",
                           bad, done_cyc - t, bus.nblocks);
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0;
      prev_a = 8'h00; prev_d = 8'h00;
      clear_log();
      test_reset();
      test_abc();
      test_len55();
      test_len56();
      test_len119_gaps();
      test_overflow();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
